// File: rtl/moka_rv32i_mem_arbiter_pkg.sv
// Shared types for the moka rv32i memory arbiter.
// FSM states, requester ids and default bus widths.
package moka_rv32i_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_LS = 1'b1;

endpackage

// File: rtl/moka_rv32i_mem_arbiter_if.sv
// Memory-side bus of the arbiter.
// master = arbiter, slave = memory.
interface moka_rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output mem_en,
    output mem_we,
    output address,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  address,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/moka_rv32i_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick.
// On a tie the requester not granted last wins.
module moka_rr_arb2
  import moka_rv32i_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    pick
);

  always_comb begin
    valid = |req;
    pick  = REQ_IF;
    if (&req) begin
      pick = ~last;
    end else if (req[1]) begin
      pick = REQ_LS;
    end
  end

endmodule

// File: rtl/moka_rv32i_mem_arbiter.sv
// Two-requester memory arbiter: IF vs LS.
// One access in flight; read = 3 cycles, write = 2.
module moka_rv32i_mem_arbiter
  import moka_rv32i_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_we,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_we,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] rd_data
);

  state_e            state_q, state_d;
  req_id_t           win_q, win_d;
  req_id_t           last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;

  logic    pick_valid;
  req_id_t pick;
  logic    access;

  moka_rr_arb2 u_arb (
    .req   ({r1_req, r0_req}),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    r0_rvalid_d = 1'b0;
    r1_rvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          win_d   = pick;
          addr_d  = pick ? r1_addr : r0_addr;
          wdata_d = pick ? r1_wdata : r0_wdata;
          we_d    = pick ? r1_we : r0_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // pointer moves only when the grant is issued
        last_d  = win_q;
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (win_q) begin
          r1_rdata_d  = rd_data;
          r1_rvalid_d = 1'b1;
        end else begin
          r0_rdata_d  = rd_data;
          r0_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      win_q       <= REQ_IF;
      last_q      <= REQ_LS;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
    end
  end

  always_comb begin
    access  = (state_q == ACCESS);
    mem_en  = access;
    mem_we  = access & we_q;
    address = access ? addr_q : '0;
    wr_data = access ? wdata_q : '0;
    r0_gnt  = access & (win_q == REQ_IF);
    r1_gnt  = access & (win_q == REQ_LS);
  end

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_moka_rv32i_mem_arbiter.sv
// Directed bench for moka_rv32i_mem_arbiter.
// Registered memory model answers reads one cycle after mem_en.
module tb_moka_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [31:0] r0_addr = '0, r1_addr = '0;
  logic        r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;

  int vectors = 0;
  int errs = 0;

  moka_rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  moka_rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .r0_req    (r0_req),
    .r0_addr   (r0_addr),
    .r0_we     (r0_we),
    .r0_wdata  (r0_wdata),
    .r1_req    (r1_req),
    .r1_addr   (r1_addr),
    .r1_we     (r1_we),
    .r1_wdata  (r1_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_en    (mif.mem_en),
    .address   (mif.address),
    .wr_data   (mif.wr_data),
    .mem_we    (mif.mem_we),
    .rd_data   (mif.rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  initial mif.rd_data = '0;
  always @(posedge clk)
    if (mif.mem_en && !mif.mem_we)
      mif.rd_data <= mem_val(mif.address);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_mem_en", 32'(mif.mem_en), 0);
    chk("rst_mem_we", 32'(mif.mem_we), 0);
    chk("rst_addr", mif.address, 0);
    chk("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 0);
    chk("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
    chk("rst_rdata0", r0_rdata, 0);
    rstn = 1'b1;

    // r0 read of 0x10
    en = 1'b1;
    r0_req = 1'b1; r0_addr = 32'h10; r0_we = 1'b0;
    tick;
    chk("rd_gnt0", 32'(r0_gnt), 1);
    chk("rd_gnt1", 32'(r1_gnt), 0);
    chk("rd_mem_en", 32'(mif.mem_en), 1);
    chk("rd_mem_we", 32'(mif.mem_we), 0);
    chk("rd_addr", mif.address, 32'h10);
    r0_req = 1'b0;
    tick;
    chk("rd_c2_mem_en", 32'(mif.mem_en), 0);
    chk("rd_c2_rvalid", 32'(r0_rvalid), 0);
    tick;
    chk("rd_c3_rvalid", 32'(r0_rvalid), 1);
    chk("rd_c3_rdata", r0_rdata, 32'hDEAD_BEEF);
    tick;
    chk("rd_c4_rvalid", 32'(r0_rvalid), 0);
    chk("rd_c4_hold", r0_rdata, 32'hDEAD_BEEF);

    // r1 write, then an r0 read issued in cycle 2
    r1_req = 1'b1; r1_addr = 32'h100; r1_we = 1'b1;
    r1_wdata = 32'h1234_5678;
    tick;
    chk("wr_gnt1", 32'(r1_gnt), 1);
    chk("wr_mem_en", 32'(mif.mem_en), 1);
    chk("wr_mem_we", 32'(mif.mem_we), 1);
    chk("wr_addr", mif.address, 32'h100);
    chk("wr_data", mif.wr_data, 32'h1234_5678);
    r1_req = 1'b0; r1_we = 1'b0;
    tick;
    chk("wr_c2_mem_en", 32'(mif.mem_en), 0);
    chk("wr_c2_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
    r0_req = 1'b1; r0_addr = 32'h20;
    tick;
    chk("wr_idle_gnt0", 32'(r0_gnt), 1);
    r0_req = 1'b0;
    tick;
    tick;
    chk("wr_rd_rvalid", 32'(r0_rvalid), 1);
    chk("wr_rd_rdata", r0_rdata, 32'hA5A5_0020);
    chk("wr_no_rvalid1", 32'(r1_rvalid), 0);

    // alternation from a fresh reset
    rstn = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
    r0_req = 1'b1; r0_addr = 32'h40;
    r1_req = 1'b1; r1_addr = 32'h80;
    for (int c = 1; c <= 12; c++) begin
      tick;
      chk($sformatf("alt_gnt0_c%0d", c), 32'(r0_gnt),
          32'((c % 6) == 1));
      chk($sformatf("alt_gnt1_c%0d", c), 32'(r1_gnt),
          32'((c % 6) == 4));
      chk($sformatf("alt_rv0_c%0d", c), 32'(r0_rvalid),
          32'((c % 6) == 3));
      chk($sformatf("alt_rv1_c%0d", c), 32'(r1_rvalid),
          32'((c % 6) == 0));
      if (c == 3) chk("alt_rdata0", r0_rdata, 32'hA5A5_0040);
      if (c == 6) chk("alt_rdata1", r1_rdata, 32'hA5A5_0080);
      if (c == 12) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
    end
    tick;
    tick;

    // en gating
    en = 1'b0;
    r0_req = 1'b1; r0_addr = 32'h30;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("en0_mem_en_%0d", i), 32'(mif.mem_en), 0);
    end
    en = 1'b1;
    tick;
    chk("en1_gnt0", 32'(r0_gnt), 1);
    en = 1'b0;
    r0_req = 1'b0;
    tick;
    tick;
    chk("en0_rvalid", 32'(r0_rvalid), 1);
    chk("en0_rdata", r0_rdata, 32'hA5A5_0030);

    // reset during RESP
    en = 1'b1;
    r0_req = 1'b1; r0_addr = 32'h50;
    tick;
    chk("rr_gnt0", 32'(r0_gnt), 1);
    r0_req = 1'b0;
    tick;
    rstn = 1'b0;
    #1;
    chk("rr_mem_en", 32'(mif.mem_en), 0);
    chk("rr_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
    chk("rr_rdata0", r0_rdata, 0);
    chk("rr_rdata1", r1_rdata, 0);
    tick;
    chk("rr_hold_rvalid", 32'(r0_rvalid), 0);
    rstn = 1'b1;
    r0_req = 1'b1; r0_addr = 32'h60;
    r1_req = 1'b1; r1_addr = 32'h70;
    tick;
    chk("rr_tie_gnt0", 32'(r0_gnt), 1);
    chk("rr_tie_gnt1", 32'(r1_gnt), 0);
    chk("rr_post_rvalid", 32'(r0_rvalid), 0);
    r0_req = 1'b0;
    r1_req = 1'b0;
    tick;
    chk("rr_c2_rvalid", 32'(r0_rvalid), 0);
    tick;
    chk("rr_c3_rvalid", 32'(r0_rvalid), 1);
    chk("rr_c3_rdata", r0_rdata, 32'hA5A5_0060);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
